hazard_ctl: RTL and testbench

- Pipeline interlock controller for the MIPS core; sequences the operand-forwarding network.
- Detects hazards that forwarding cannot cover: load-use in EX, branch-compare in ID against a load in MEM, and HI/LO access during a multi-cycle mul/div.
- Drives the shared `pause` (freeze PC/IF/ID and the forward-unit rn registers) and a bubble-insert into ID/EX.
- Owns the mul/div busy counter and issues the HI/LO write strobe.

---
 rtl/hazard_ctl_pkg.sv | 17 +
 rtl/hazard_ctl_hz_match.sv | 15 +
 rtl/hazard_ctl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared types and defaults for the pipeline interlock controller.
// Optional feature macro: HAZ_STATS_EN (adds a 32-bit stall counter output).
package hazard_ctl_pkg;

    localparam int unsigned REG_W          = 5;
    localparam int unsigned HZ_MUL_LAT_DEF = 4;
    localparam int unsigned HZ_DIV_LAT_DEF = 34;
    localparam int unsigned HZ_CNT_W_DEF   = 6;
    localparam int unsigned HZ_STATS_W     = 32;

    typedef enum logic [1:0] {
        HZ_IDLE    = 2'd0,
        HZ_MD_RUN  = 2'd1,
        HZ_MD_DONE = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctl_hz_match.sv
// One source-vs-destination register compare; r0 never matches.
module hz_match
    import hazard_ctl_pkg::*;
(
    input  logic [REG_W-1:0] i_rn,
    input  logic             i_use,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_en,
    output logic             o_match_c
);

    // Match needs a live read, a live write and a non-zero register.
    assign o_match_c = i_use & i_en & (i_rn != '0) & (i_rn == i_rd);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline interlock controller: load-use / branch-compare / HI-LO stalls
// and the mul/div busy sequencer with its HI/LO write strobe.
// Optional feature macro: HAZ_STATS_EN (adds o_stall_cnt, 32-bit pause-cycle count).
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int unsigned MUL_LAT = HZ_MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = HZ_DIV_LAT_DEF,
    parameter int unsigned CNT_W   = HZ_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W-1:0]      i_id_rs,
    input  logic [REG_W-1:0]      i_id_rt,
    input  logic                  i_id_use_rs,
    input  logic                  i_id_use_rt,
    input  logic                  i_id_is_cmp,
    input  logic                  i_id_hilo,
    input  logic [REG_W-1:0]      i_ex_rd,
    input  logic                  i_ex_we,
    input  logic                  i_ex_load,
    input  logic [REG_W-1:0]      i_mem_rd,
    input  logic                  i_mem_load,
    input  logic                  i_md_start,
    input  logic                  i_md_is_div,
    input  logic                  i_flush,
    output logic                  o_pause,
    output logic                  o_id_bubble,
    output logic                  o_md_busy,
`ifdef HAZ_STATS_EN
    output logic [HZ_STATS_W-1:0] o_stall_cnt,
`endif
    output logic                  o_md_done
);

    localparam logic [CNT_W-1:0] L_MUL = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] L_DIV = CNT_W'(DIV_LAT);

    logic      w_rs_ex;
    logic      w_rt_ex;
    logic      w_rs_mem;
    logic      w_rt_mem;
    logic      w_ld_haz;
    logic      w_cmp_haz;
    logic      w_md_haz;
    logic      w_stall;

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    hz_state_e        w_load_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_lat;
    logic             r_md_busy;
    logic             r_md_done;

    hz_match u_rs_ex (
        .i_rn      (i_id_rs),
        .i_use     (i_id_use_rs),
        .i_rd      (i_ex_rd),
        .i_en      (i_ex_we),
        .o_match_c (w_rs_ex)
    );

    hz_match u_rt_ex (
        .i_rn      (i_id_rt),
        .i_use     (i_id_use_rt),
        .i_rd      (i_ex_rd),
        .i_en      (i_ex_we),
        .o_match_c (w_rt_ex)
    );

    hz_match u_rs_mem (
        .i_rn      (i_id_rs),
        .i_use     (i_id_use_rs),
        .i_rd      (i_mem_rd),
        .i_en      (i_mem_load),
        .o_match_c (w_rs_mem)
    );

    hz_match u_rt_mem (
        .i_rn      (i_id_rt),
        .i_use     (i_id_use_rt),
        .i_rd      (i_mem_rd),
        .i_en      (i_mem_load),
        .o_match_c (w_rt_mem)
    );

    // Hazard terms; busy is masked in reset so only a fresh md_start stalls HI/LO readers.
    assign w_ld_haz  = i_ex_load & (w_rs_ex | w_rt_ex);
    assign w_cmp_haz = i_id_is_cmp & (w_rs_mem | w_rt_mem | w_rs_ex | w_rt_ex);
    assign w_md_haz  = i_id_hilo & ((r_md_busy & ~rst) | i_md_start);
    assign w_stall   = (w_ld_haz | w_cmp_haz | w_md_haz) & ~i_flush;

    assign o_pause     = w_stall;
    assign o_id_bubble = w_stall;
    assign o_md_busy   = r_md_busy;
    assign o_md_done   = r_md_done;

    // Latency of the op being issued and where a fresh issue lands.
    assign w_lat        = i_md_is_div ? L_DIV : L_MUL;
    assign w_load_state = (w_lat == CNT_W'(1)) ? HZ_MD_DONE : HZ_MD_RUN;

    // Next-state and counter for the mul/div sequencer; any md_start reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            HZ_IDLE: begin
                if (i_md_start) begin
                    w_cnt_nxt   = w_lat - CNT_W'(1);
                    w_state_nxt = w_load_state;
                end
            end
            HZ_MD_RUN: begin
                if (i_md_start) begin
                    w_cnt_nxt   = w_lat - CNT_W'(1);
                    w_state_nxt = w_load_state;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = HZ_MD_DONE;
                    end
                end
            end
            HZ_MD_DONE: begin
                if (i_md_start) begin
                    w_cnt_nxt   = w_lat - CNT_W'(1);
                    w_state_nxt = w_load_state;
                end else begin
                    w_state_nxt = HZ_IDLE;
                end
            end
            default: begin
                w_state_nxt = HZ_IDLE;
            end
        endcase
    end

    // State register with busy/done decoded into flops from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HZ_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_md_busy <= (w_state_nxt == HZ_MD_RUN);
            r_md_done <= (w_state_nxt == HZ_MD_DONE);
        end
    end

`ifdef HAZ_STATS_EN
    logic [HZ_STATS_W-1:0] r_stall_cnt;

    // Free-running count of pause cycles, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + HZ_STATS_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a reference model.
module tb_hazard_ctl;

    localparam int MUL_L = 4;
    localparam int DIV_L = 34;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_is_cmp, id_hilo;
    logic       ex_we, ex_load, mem_load, md_start, md_is_div, flush;
    logic       pause, id_bubble, md_busy, md_done;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .i_id_rs     (id_rs),
        .i_id_rt     (id_rt),
        .i_id_use_rs (id_use_rs),
        .i_id_use_rt (id_use_rt),
        .i_id_is_cmp (id_is_cmp),
        .i_id_hilo   (id_hilo),
        .i_ex_rd     (ex_rd),
        .i_ex_we     (ex_we),
        .i_ex_load   (ex_load),
        .i_mem_rd    (mem_rd),
        .i_mem_load  (mem_load),
        .i_md_start  (md_start),
        .i_md_is_div (md_is_div),
        .i_flush     (flush),
        .o_pause     (pause),
        .o_id_bubble (id_bubble),
        .o_md_busy   (md_busy),
`ifdef HAZ_STATS_EN
        .o_stall_cnt (stall_cnt),
`endif
        .o_md_done   (md_done)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       cmp;
        logic       hilo;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_load;
        logic [4:0] mem_rd;
        logic       mem_load;
        logic       md_start;
        logic       md_div;
        logic       flush;
    } in_t;

    typedef struct {
        string name;
        in_t   v;
        logic  exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic cmp, logic hilo, logic [4:0] exrd, logic exwe,
                               logic exld, logic [4:0] memrd, logic memld,
                               logic mdst, logic fl);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.cmp = cmp; v.hilo = hilo;
        v.ex_rd = exrd; v.ex_we = exwe; v.ex_load = exld;
        v.mem_rd = memrd; v.mem_load = memld;
        v.md_start = mdst; v.md_div = 1'b0; v.flush = fl;
        return v;
    endfunction

    // Reference stall decision written from the hazard rules over both sources.
    function automatic logic model_pause(in_t v, logic busy);
        logic [4:0] src [2];
        logic       uses [2];
        logic       stall;
        src[0] = v.rs; uses[0] = v.urs;
        src[1] = v.rt; uses[1] = v.urt;
        stall = v.hilo && (busy || v.md_start);
        for (int i = 0; i < 2; i++) begin
            if (uses[i] && src[i] != 5'd0) begin
                if (v.ex_we && src[i] == v.ex_rd && (v.ex_load || v.cmp)) stall = 1'b1;
                if (v.cmp && v.mem_load && src[i] == v.mem_rd) stall = 1'b1;
            end
        end
        return stall && !v.flush;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs mid-period and settle before sampling.
    task automatic cyc(input in_t v, input logic r);
        @(negedge clk);
        rst = r;
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
        id_is_cmp = v.cmp; id_hilo = v.hilo;
        ex_rd = v.ex_rd; ex_we = v.ex_we; ex_load = v.ex_load;
        mem_rd = v.mem_rd; mem_load = v.mem_load;
        md_start = v.md_start; md_is_div = v.md_div; flush = v.flush;
        #1;
    endtask

    task automatic do_reset();
        in_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(idle, 1'b1);
        cyc(idle, 1'b1);
        cyc(idle, 1'b0);
    endtask

    initial begin
        vec_t tv [18];
        in_t  idle, v;
        int   t, md_end, exp_stall;
        logic busy_m, done_m, ep, r;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed combinational vectors (sequencer idle throughout).
        tv[0]  = '{"ld_use_rs",   mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0), 1'b1};
        tv[1]  = '{"ld_use_rt",   mk(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0), 1'b1};
        tv[2]  = '{"ld_use_off",  mk(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0), 1'b0};
        tv[3]  = '{"ld_zero_reg", mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'b0};
        tv[4]  = '{"alu_no_cmp",  mk(5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0), 1'b0};
        tv[5]  = '{"ld_no_we",    mk(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0), 1'b0};
        tv[6]  = '{"cmp_mem_ld",  mk(0, 9, 0, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0), 1'b1};
        tv[7]  = '{"cmp_mem_alu", mk(0, 9, 0, 1, 1, 0, 0, 0, 0, 9, 0, 0, 0), 1'b0};
        tv[8]  = '{"cmp_ex_alu",  mk(3, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0), 1'b1};
        tv[9]  = '{"cmp_ex_nowe", mk(3, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0), 1'b0};
        tv[10] = '{"mem_ld_nocmp",mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0), 1'b0};
        tv[11] = '{"cmp_mem_r0",  mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0};
        tv[12] = '{"hilo_idle",   mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        tv[13] = '{"flush_ld",    mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1), 1'b0};
        tv[14] = '{"flush_cmp",   mk(0, 9, 0, 1, 1, 0, 0, 0, 0, 9, 1, 0, 1), 1'b0};
        tv[15] = '{"reg_differ",  mk(5, 6, 1, 1, 1, 0, 6, 1, 1, 7, 1, 0, 0), 1'b1};
        tv[16] = '{"md_no_hilo",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0};
        tv[17] = '{"hilo_start",  mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), 1'b1};

        // Reset state.
        do_reset();
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_done", 32'(md_done), 0);
        chk("rst_pause", 32'(pause), 0);
`ifdef HAZ_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        for (int i = 0; i < 18; i++) begin
            cyc(tv[i].v, 1'b0);
            chk({tv[i].name, "_pause"}, 32'(pause), 32'(tv[i].exp));
            chk({tv[i].name, "_bubble"}, 32'(id_bubble), 32'(tv[i].exp));
        end

        // Load-use: one stall, then the load sits in MEM and the consumer goes.
        do_reset();
        cyc(mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0), 1'b0);
        chk("lu_seq_c0", 32'(pause), 1);
        cyc(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0), 1'b0);
        chk("lu_seq_c1", 32'(pause), 0);

        // Divide then MFHI: 33 stall cycles, release with md_done at cycle 34.
        do_reset();
        v = idle; v.md_start = 1'b1; v.md_div = 1'b1;
        cyc(v, 1'b0);
        chk("div_c0_pause", 32'(pause), 0);
        v = idle; v.hilo = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            cyc(v, 1'b0);
            chk($sformatf("div_c%0d_pause", k), 32'(pause), 1);
            chk($sformatf("div_c%0d_busy", k), 32'(md_busy), 1);
            chk($sformatf("div_c%0d_done", k), 32'(md_done), 0);
        end
        cyc(v, 1'b0);
        chk("div_c34_pause", 32'(pause), 0);
        chk("div_c34_done", 32'(md_done), 1);
        chk("div_c34_busy", 32'(md_busy), 0);
`ifdef HAZ_STATS_EN
        chk("div_stall_cnt", stall_cnt, 33);
`endif
        cyc(idle, 1'b0);
        chk("div_c35_done", 32'(md_done), 0);
        chk("div_c35_busy", 32'(md_busy), 0);

        // Back-to-back multiplies: second issue in the first one's done cycle.
        v = idle; v.md_start = 1'b1;
        cyc(v, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc((k == 4) ? v : idle, 1'b0);
            chk($sformatf("mul_t%0d_busy", k), 32'(md_busy),
                32'((k != 4 && k != 8 && k != 9) ? 1 : 0));
            chk($sformatf("mul_t%0d_done", k), 32'(md_done),
                32'((k == 4 || k == 8) ? 1 : 0));
        end

        // Reset in multiply cycle 2 abandons the op with no strobe.
        cyc(v, 1'b0);
        cyc(idle, 1'b0);
        chk("mulrst_t1_busy", 32'(md_busy), 1);
        cyc(idle, 1'b1);
        cyc(idle, 1'b0);
        chk("mulrst_t3_busy", 32'(md_busy), 0);
        chk("mulrst_t3_done", 32'(md_done), 0);
        cyc(idle, 1'b0);
        chk("mulrst_t4_done", 32'(md_done), 0);
        chk("mulrst_t4_busy", 32'(md_busy), 0);

        // Randomized run against the cycle-index model of the sequencer.
        t = 0; md_end = -1; exp_stall = 0;
        for (int i = 0; i < 2000; i++) begin
            v.rs       = 5'($urandom_range(0, 3));
            v.rt       = 5'($urandom_range(0, 3));
            v.urs      = 1'($urandom_range(0, 1));
            v.urt      = 1'($urandom_range(0, 1));
            v.cmp      = ($urandom_range(0, 3) == 0);
            v.hilo     = ($urandom_range(0, 2) == 0);
            v.ex_rd    = 5'($urandom_range(0, 3));
            v.ex_we    = 1'($urandom_range(0, 1));
            v.ex_load  = 1'($urandom_range(0, 1));
            v.mem_rd   = 5'($urandom_range(0, 3));
            v.mem_load = 1'($urandom_range(0, 1));
            v.md_start = ($urandom_range(0, 11) == 0);
            v.md_div   = 1'($urandom_range(0, 1));
            v.flush    = ($urandom_range(0, 7) == 0);
            r = (i == 0) || ($urandom_range(0, 299) == 0);
            cyc(v, r);

            busy_m = (md_end >= 0) && (t < md_end);
            done_m = (md_end >= 0) && (t == md_end);
            ep     = model_pause(v, busy_m && !r);
            chk("rnd_pause", 32'(pause), 32'(ep));
            chk("rnd_bubble", 32'(id_bubble), 32'(ep));
            if (i > 0) begin
                chk("rnd_busy", 32'(md_busy), 32'(busy_m));
                chk("rnd_done", 32'(md_done), 32'(done_m));
`ifdef HAZ_STATS_EN
                chk("rnd_stall_cnt", stall_cnt, 32'(exp_stall));
`endif
            end

            if (r) begin
                md_end    = -1;
                exp_stall = 0;
            end else begin
                if (ep) exp_stall++;
                if (v.md_start) md_end = t + (v.md_div ? DIV_L : MUL_L);
            end
            t++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
